// File: rtl/motor_offset_scheduler.sv
// Motor mixer that time-shares one offset generator between pitch and roll,
// then adds both offset sets onto the base throttle for four saturated motor commands.
module motor_offset_scheduler #(
  parameter logic [7:0] MAX_CMD = 8'd255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sample_valid,
  output logic       sample_ready,
  input  logic [7:0] pitch_rec_val,
  input  logic [7:0] roll_rec_val,
  input  logic [7:0] throttle,
  input  logic       arm,
  output logic       lut_sel,
  output logic [7:0] lut_val,
  input  logic [7:0] lut_off_1,
  input  logic [7:0] lut_off_2,
  input  logic [7:0] lut_off_3,
  input  logic [7:0] lut_off_4,
  output logic [7:0] motor_1_cmd,
  output logic [7:0] motor_2_cmd,
  output logic [7:0] motor_3_cmd,
  output logic [7:0] motor_4_cmd,
  output logic       cmd_valid,
  output logic       sat_flag,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PITCH = 2'd1,
    S_ROLL  = 2'd2,
    S_SUM   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       pitch_q, pitch_d;
  logic [7:0]       roll_q, roll_d;
  logic [7:0]       thr_q, thr_d;
  logic [3:0][7:0]  poff_q, poff_d;
  logic [3:0][7:0]  roff_q, roff_d;
  logic [3:0][7:0]  motor_q, motor_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic             sat_q, sat_d;
  logic [3:0][9:0]  sum_s;

  function automatic logic [7:0] clip_cmd(input logic [9:0] sum);
    if (sum > {2'b00, MAX_CMD}) begin
      return MAX_CMD;
    end else begin
      return sum[7:0];
    end
  endfunction

  // Sequencer, generator steering and command arithmetic
  always_comb begin
    state_d     = state_q;
    pitch_d     = pitch_q;
    roll_d      = roll_q;
    thr_d       = thr_q;
    poff_d      = poff_q;
    roff_d      = roff_q;
    motor_d     = motor_q;
    sat_d       = sat_q;
    cmd_valid_d = 1'b0;
    lut_sel     = 1'b0;
    lut_val     = 8'd0;
    for (int i = 0; i < 4; i++) begin
      sum_s[i] = {2'b00, thr_q} + {2'b00, poff_q[i]} + {2'b00, roff_q[i]};
    end
    case (state_q)
      S_IDLE: begin
        if (sample_valid) begin
          pitch_d = pitch_rec_val;
          roll_d  = roll_rec_val;
          thr_d   = throttle;
          state_d = S_PITCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PITCH: begin
        lut_val = pitch_q;
        poff_d  = {lut_off_4, lut_off_3, lut_off_2, lut_off_1};
        state_d = S_ROLL;
      end
      S_ROLL: begin
        lut_sel = 1'b1;
        lut_val = roll_q;
        roff_d  = {lut_off_4, lut_off_3, lut_off_2, lut_off_1};
        state_d = S_SUM;
      end
      S_SUM: begin
        cmd_valid_d = 1'b1;
        state_d     = S_IDLE;
        if (arm) begin
          sat_d = 1'b0;
          for (int i = 0; i < 4; i++) begin
            motor_d[i] = clip_cmd(sum_s[i]);
            if (sum_s[i] > {2'b00, MAX_CMD}) begin
              sat_d = 1'b1;
            end else begin
              sat_d = sat_d;
            end
          end
        end else begin
          motor_d = '0;
          sat_d   = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pitch_q     <= 8'd0;
      roll_q      <= 8'd0;
      thr_q       <= 8'd0;
      poff_q      <= '0;
      roff_q      <= '0;
      motor_q     <= '0;
      cmd_valid_q <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pitch_q     <= pitch_d;
      roll_q      <= roll_d;
      thr_q       <= thr_d;
      poff_q      <= poff_d;
      roff_q      <= roff_d;
      motor_q     <= motor_d;
      cmd_valid_q <= cmd_valid_d;
      sat_q       <= sat_d;
    end
  end

  assign sample_ready = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign motor_1_cmd  = motor_q[0];
  assign motor_2_cmd  = motor_q[1];
  assign motor_3_cmd  = motor_q[2];
  assign motor_4_cmd  = motor_q[3];
  assign cmd_valid    = cmd_valid_q;
  assign sat_flag     = sat_q;

endmodule

// File: tb/tb_motor_offset_scheduler.sv
// Directed bench for motor_offset_scheduler with a behavioural offset generator.
module tb_motor_offset_scheduler;

  logic       clk;
  logic       rst_n;
  logic       sample_valid;
  logic       sample_ready;
  logic [7:0] pitch_rec_val;
  logic [7:0] roll_rec_val;
  logic [7:0] throttle;
  logic       arm;
  logic       lut_sel;
  logic [7:0] lut_val;
  logic [7:0] lut_off_1, lut_off_2, lut_off_3, lut_off_4;
  logic [7:0] motor_1_cmd, motor_2_cmd, motor_3_cmd, motor_4_cmd;
  logic       cmd_valid;
  logic       sat_flag;
  logic       busy;

  int n_vec;
  int n_err;

  motor_offset_scheduler #(.MAX_CMD(8'd255)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .pitch_rec_val(pitch_rec_val),
    .roll_rec_val (roll_rec_val),
    .throttle     (throttle),
    .arm          (arm),
    .lut_sel      (lut_sel),
    .lut_val      (lut_val),
    .lut_off_1    (lut_off_1),
    .lut_off_2    (lut_off_2),
    .lut_off_3    (lut_off_3),
    .lut_off_4    (lut_off_4),
    .motor_1_cmd  (motor_1_cmd),
    .motor_2_cmd  (motor_2_cmd),
    .motor_3_cmd  (motor_3_cmd),
    .motor_4_cmd  (motor_4_cmd),
    .cmd_valid    (cmd_valid),
    .sat_flag     (sat_flag),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Offset generator model
  always_comb begin
    {lut_off_1, lut_off_2, lut_off_3, lut_off_4} = {8'd0, 8'd0, 8'd0, 8'd0};
    if (lut_sel == 1'b0) begin
      if (lut_val <= 8'd3) begin
        {lut_off_1, lut_off_2, lut_off_3, lut_off_4} = {8'd0, 8'd0, 8'd6, 8'd6};
      end else if (lut_val >= 8'd23 && lut_val <= 8'd25) begin
        {lut_off_1, lut_off_2, lut_off_3, lut_off_4} = {8'd1, 8'd1, 8'd0, 8'd0};
      end
    end else if (lut_val == 8'd5) begin
      {lut_off_1, lut_off_2, lut_off_3, lut_off_4} = {8'd2, 8'd0, 8'd2, 8'd0};
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    sample_valid = 1'b0;
    pitch_rec_val = 8'd0;
    roll_rec_val = 8'd0;
    throttle = 8'd0;
    arm = 1'b1;
    #1;
    n_vec++;
    if ({motor_1_cmd, motor_2_cmd, motor_3_cmd, motor_4_cmd, cmd_valid, sat_flag, busy, lut_sel, lut_val} !== 45'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got cmds %0d %0d %0d %0d cv=%0b sat=%0b busy=%0b sel=%0b val=%0d, want all 0",
               motor_1_cmd, motor_2_cmd, motor_3_cmd, motor_4_cmd, cmd_valid, sat_flag, busy, lut_sel, lut_val);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    n_vec++;
    if ({sample_ready, busy} !== 2'b10) begin
      n_err++;
      $display("FAIL reset_release: got ready=%0b busy=%0b, want ready=1 busy=0", sample_ready, busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic run_sample(input string tag, input logic [7:0] p, input logic [7:0] r,
                            input logic [7:0] t, input logic a, input logic [31:0] exp_cmd,
                            input logic exp_sat);
    pitch_rec_val = p;
    roll_rec_val  = r;
    throttle      = t;
    arm           = a;
    sample_valid  = 1'b1;
    n_vec++;
    if (sample_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s_ready: got %0b, want 1", tag, sample_ready);
    end
    @(posedge clk); #1;
    sample_valid  = 1'b0;
    pitch_rec_val = 8'd100;
    roll_rec_val  = 8'd5;
    throttle      = 8'd0;
    n_vec++;
    if ({busy, sample_ready, lut_sel, lut_val} !== {1'b1, 1'b0, 1'b0, p}) begin
      n_err++;
      $display("FAIL %s_pitch_phase: got busy=%0b rdy=%0b sel=%0b val=%0d, want 1 0 0 %0d",
               tag, busy, sample_ready, lut_sel, lut_val, p);
    end
    @(posedge clk); #1;
    n_vec++;
    if ({busy, lut_sel, lut_val, cmd_valid} !== {1'b1, 1'b1, r, 1'b0}) begin
      n_err++;
      $display("FAIL %s_roll_phase: got busy=%0b sel=%0b val=%0d cv=%0b, want 1 1 %0d 0",
               tag, busy, lut_sel, lut_val, cmd_valid, r);
    end
    @(posedge clk); #1;
    n_vec++;
    if ({busy, lut_sel, lut_val, cmd_valid} !== {1'b1, 1'b0, 8'd0, 1'b0}) begin
      n_err++;
      $display("FAIL %s_sum_phase: got busy=%0b sel=%0b val=%0d cv=%0b, want 1 0 0 0",
               tag, busy, lut_sel, lut_val, cmd_valid);
    end
    @(posedge clk); #1;
    n_vec++;
    if ({cmd_valid, busy, motor_1_cmd, motor_2_cmd, motor_3_cmd, motor_4_cmd, sat_flag} !==
        {1'b1, 1'b0, exp_cmd, exp_sat}) begin
      n_err++;
      $display("FAIL %s_result: got cv=%0b busy=%0b cmd={%0d,%0d,%0d,%0d} sat=%0b, want cv=1 busy=0 cmd={%0d,%0d,%0d,%0d} sat=%0b",
               tag, cmd_valid, busy, motor_1_cmd, motor_2_cmd, motor_3_cmd, motor_4_cmd, sat_flag,
               exp_cmd[31:24], exp_cmd[23:16], exp_cmd[15:8], exp_cmd[7:0], exp_sat);
    end
    @(posedge clk); #1;
    n_vec++;
    if ({cmd_valid, motor_1_cmd, motor_2_cmd, motor_3_cmd, motor_4_cmd, sat_flag} !==
        {1'b0, exp_cmd, exp_sat}) begin
      n_err++;
      $display("FAIL %s_hold: got cv=%0b cmd={%0d,%0d,%0d,%0d} sat=%0b, want cv=0 and result held",
               tag, cmd_valid, motor_1_cmd, motor_2_cmd, motor_3_cmd, motor_4_cmd, sat_flag);
    end
  endtask

  task automatic test_basic();
    run_sample("basic", 8'd2, 8'd20, 8'd100, 1'b1, {8'd100, 8'd100, 8'd106, 8'd106}, 1'b0);
  endtask

  task automatic test_offsets();
    run_sample("offsets", 8'd24, 8'd5, 8'd50, 1'b1, {8'd53, 8'd51, 8'd52, 8'd50}, 1'b0);
  endtask

  task automatic test_saturation();
    run_sample("saturation", 8'd0, 8'd5, 8'd250, 1'b1, {8'd252, 8'd250, 8'd255, 8'd255}, 1'b1);
  endtask

  task automatic test_mid_reset();
    pitch_rec_val = 8'd24;
    roll_rec_val  = 8'd5;
    throttle      = 8'd50;
    arm           = 1'b1;
    sample_valid  = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if ({busy, lut_sel} !== 2'b11) begin
      n_err++;
      $display("FAIL midrst_in_roll: got busy=%0b sel=%0b, want 1 1", busy, lut_sel);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({motor_1_cmd, motor_2_cmd, motor_3_cmd, motor_4_cmd, cmd_valid, sat_flag, busy, lut_sel, lut_val} !== 45'd0) begin
      n_err++;
      $display("FAIL midrst_outputs: got cmds %0d %0d %0d %0d cv=%0b sat=%0b busy=%0b sel=%0b val=%0d, want all 0",
               motor_1_cmd, motor_2_cmd, motor_3_cmd, motor_4_cmd, cmd_valid, sat_flag, busy, lut_sel, lut_val);
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      n_vec++;
      if (cmd_valid !== 1'b0) begin
        n_err++;
        $display("FAIL midrst_no_pulse: cycle %0d got cv=%0b, want 0", k, cmd_valid);
      end
    end
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (sample_ready !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_ready: got %0b, want 1", sample_ready);
    end
    run_sample("after_rst", 8'd2, 8'd20, 8'd100, 1'b1, {8'd100, 8'd100, 8'd106, 8'd106}, 1'b0);
  endtask

  task automatic test_disarmed();
    run_sample("disarmed", 8'd0, 8'd5, 8'd200, 1'b0, 32'd0, 1'b0);
    arm = 1'b1;
  endtask

  task automatic test_back_to_back();
    int accepts;
    int pulses;
    int last;
    accepts = 0;
    pulses  = 0;
    last    = -1;
    arm     = 1'b1;
    for (int c = 0; c < 20; c++) begin
      sample_valid = (c < 12);
      if (c % 4 == 0) begin
        pitch_rec_val = 8'd24;
        roll_rec_val  = 8'd5;
        throttle      = 8'd50;
      end else begin
        pitch_rec_val = 8'd0;
        roll_rec_val  = 8'd7;
        throttle      = 8'd250;
      end
      if (sample_ready && sample_valid) accepts++;
      @(posedge clk); #1;
      if (cmd_valid === 1'b1) begin
        pulses++;
        n_vec++;
        if ((last < 0 && c != 3) || (last >= 0 && c - last != 4)) begin
          n_err++;
          $display("FAIL b2b_spacing: pulse at cycle %0d after previous %0d, want first at 3 then every 4", c, last);
        end
        n_vec++;
        if ({motor_1_cmd, motor_2_cmd, motor_3_cmd, motor_4_cmd, sat_flag} !== {8'd53, 8'd51, 8'd52, 8'd50, 1'b0}) begin
          n_err++;
          $display("FAIL b2b_result: got {%0d,%0d,%0d,%0d} sat=%0b, want {53,51,52,50} sat=0",
                   motor_1_cmd, motor_2_cmd, motor_3_cmd, motor_4_cmd, sat_flag);
        end
        last = c;
      end
    end
    sample_valid = 1'b0;
    n_vec++;
    if (accepts !== 3) begin
      n_err++;
      $display("FAIL b2b_accepts: got %0d, want 3", accepts);
    end
    n_vec++;
    if (pulses !== 3) begin
      n_err++;
      $display("FAIL b2b_pulses: got %0d, want 3", pulses);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_offsets();
    test_saturation();
    test_mid_reset();
    test_disarmed();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/motor_offset_scheduler.md
MOTOR_OFFSET_SCHEDULER -- requirements
Module: motor_offset_scheduler

Interface
REQ-001 SHALL have parameter: MAX_CMD, 8'd255, saturation ceiling for every motor command.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: sample_valid  input  1  new attitude sample offered.
REQ-005 SHALL have port: sample_ready  output  1  sample accepted on this edge when high with sample_valid.
REQ-006 SHALL have port: pitch_rec_val  input  8  received pitch value.
REQ-007 SHALL have port: roll_rec_val  input  8  received roll value.
REQ-008 SHALL have port: throttle  input  8  base throttle applied to all four motors.
REQ-009 SHALL have port: arm  input  1  motors enabled when high.
REQ-010 SHALL have port: lut_sel  output  1  shared offset generator select: 0 = pitch, 1 = roll.
REQ-011 SHALL have port: lut_val  output  8  value presented to the shared offset generator.
REQ-012 SHALL have port: lut_off_1..lut_off_4  input  8 each  combinational offsets returned by the generator, valid in the same cycle.
REQ-013 SHALL have port: motor_1_cmd..motor_4_cmd  output  8 each  registered motor commands.
REQ-014 SHALL have port: cmd_valid  output  1  one-cycle pulse when the motor commands update.
REQ-015 SHALL have port: sat_flag  output  1  registered; high if any motor clipped in the last update.
REQ-016 SHALL have port: busy  output  1  high in any state other than IDLE.

Function
REQ-017 SHALL implement the FSM IDLE -> PITCH -> ROLL -> SUM -> IDLE, with exactly one clock per non-IDLE state.
REQ-018 SHALL drive sample_ready = 1 only in IDLE, combinationally from state.
REQ-019 SHALL, on an edge in IDLE with sample_valid=1, latch pitch_rec_val, roll_rec_val and throttle, then move to PITCH.
REQ-020 SHALL drive lut_sel=0, lut_val=latched pitch in PITCH, and capture lut_off_1..4 as the pitch offsets on the exiting edge.
REQ-021 SHALL drive lut_sel=1, lut_val=latched roll in ROLL, and capture lut_off_1..4 as the roll offsets on the exiting edge.
REQ-022 SHALL drive lut_sel=0 and lut_val=0 in IDLE and SUM.
REQ-023 SHALL, on the edge leaving SUM, compute each motor_n_cmd in 10-bit unsigned arithmetic as throttle + pitch offset n + roll offset n, then clip to MAX_CMD.
REQ-024 SHALL sample arm on the edge leaving SUM; if arm=0, all motor_n_cmd load 0 and sat_flag loads 0.
REQ-025 SHALL set sat_flag=1 on that edge if any unclipped sum exceeds MAX_CMD, and 0 otherwise.
REQ-026 SHALL pulse cmd_valid high for exactly the one cycle following the SUM exit edge, i.e. 3 clocks after the accept edge.
REQ-027 SHALL hold motor_n_cmd and sat_flag between updates.
REQ-028 SHALL ignore sample_valid while busy; a sample held by the requester is accepted in the next IDLE cycle, giving a maximum throughput of one sample per 4 clocks.
REQ-029 SHALL leave the latched inputs unaffected by input changes after the accept edge.
REQ-030 SHALL keep the captured pitch and roll offsets internal; only motor_n_cmd is externally visible.

Reset
REQ-031 SHALL, while rst_n=0 and regardless of clk, force: state IDLE, motor_1..4_cmd=0, cmd_valid=0, sat_flag=0, busy=0, lut_sel=0, lut_val=0, internal latches=0.
REQ-032 SHALL, when reset asserts mid-sequence, abort with no cmd_valid pulse; after release, sample_ready=1 and the next sample starts a fresh sequence.

Verification
REQ-033 SHALL have a bench that models the generator as follows.
- lut_sel=0: value 0..3 -> offsets {0,0,6,6}; 23..25 -> {1,1,0,0}; else {0,0,0,0}.
- lut_sel=1: {2,0,2,0} for value 5, else all 0.
REQ-034 SHALL be covered: rst_n low mid-ROLL -> all outputs 0 immediately, no cmd_valid, sample_ready=1 after release.
REQ-035 SHALL be covered: pitch=2, roll=20, throttle=100, arm=1 -> cmd {100,100,106,106}, sat_flag=0, cmd_valid 3 clocks after accept.
REQ-036 SHALL be covered: pitch=24, roll=5, throttle=50 -> cmd {53,51,2+50,50} = {53,51,52,50}.
REQ-037 SHALL be covered: pitch=0, roll=5, throttle=250 -> cmd {252,250,255,255}, sat_flag=1.
REQ-038 SHALL be covered: arm=0 with pitch=0, throttle=200 -> cmd {0,0,0,0}, cmd_valid still pulses.
REQ-039 SHALL be covered: sample_valid held high for 12 clocks -> exactly 3 accepts and 3 cmd_valid pulses spaced 4 clocks apart; input changes after accept do not affect the result.
